// File: rtl/rng_scheduler.sv
// Round-robin scheduler sharing one free-running 8-bit LFSR; returns bounded values by rejection sampling.
// Optional macro RNG_SCHED_MASK_EN masks each sample to the bound's bit width before comparing.
module rng_scheduler #(
    parameter int         NUM_REQ = 4,
    parameter logic [7:0] SEED    = 8'h01
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] limit,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           rnd_data,
    output logic                 busy
);
    localparam int         IW       = $clog2(NUM_REQ);
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    q;
    logic [7:0]    s;
    logic [7:0]    cand;
    logic [7:0]    lim_q;
    logic          accept;
    logic [IW-1:0] idx;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] pos;
    logic          found;
    logic [7:0]    lim_arr [NUM_REQ];

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int p;
        p = int'(base) + k;
        if (p >= NUM_REQ) p = p - NUM_REQ;
        return IW'(p);
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : gen_lim
        assign lim_arr[i] = limit[8*i +: 8];
    end

    // Free-running LFSR; never reaches zero, so s = q - 1 spans 0..254.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= SEED_EFF;
        else        q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end

    assign s = q - 8'd1;

    always_comb begin
        found     = 1'b0;
        grant_idx = rr_ptr;
        pos       = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = wrap_add(rr_ptr, k);
            if (!found && req[pos]) begin
                found     = 1'b1;
                grant_idx = pos;
            end
        end
    end

`ifdef RNG_SCHED_MASK_EN
    logic [7:0] mask;
    logic [7:0] lim_m1;

    // Smallest all-ones mask covering lim_q-1 keeps the expected retry count below two.
    always_comb begin
        lim_m1 = lim_q - 8'd1;
        mask   = 8'h00;
        if (lim_q == 8'h00) begin
            mask = 8'hFF;
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (mask < lim_m1) mask = {mask[6:0], 1'b1};
            end
        end
        cand = s & mask;
    end
`else
    assign cand = s;
`endif

    assign accept = (lim_q == 8'h00) || (cand < lim_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (found) state_nxt = DRAW;
            DRAW: begin
                if (!req[idx])   state_nxt = IDLE;
                else if (accept) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack  = '0;
        busy = (state != IDLE);
        if (state == DONE) ack[idx] = 1'b1;
    end

    // Grant bookkeeping: limit is captured only at grant; an abandoned draw leaves rr_ptr alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            lim_q    <= 8'h00;
            rr_ptr   <= '0;
            rnd_data <= 8'h00;
        end else begin
            if (state == IDLE && found) begin
                idx   <= grant_idx;
                lim_q <= lim_arr[grant_idx];
            end
            if (state == DRAW && req[idx] && accept) rnd_data <= cand;
            if (state == DONE) rr_ptr <= wrap_add(idx, 1);
        end
    end
endmodule

// File: doc/rng_scheduler.md
Name: rng_scheduler

Overview:
- Shares one 8-bit maximal-length LFSR between NUM_REQ game-logic requesters, e.g. encounter roll, damage roll, crit check and catch roll.
- Grants requesters round-robin and returns one uniform value per grant in the range [0, limit).
- Uses rejection sampling to produce the bounded value.
- Sits between the battle/overworld FSMs and the shared randomness source.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- SEED, 8'h01, LFSR reset value. A zero SEED is replaced by 8'h01.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level; held high until the matching ack.
- limit  in  8*NUM_REQ  per-requester exclusive upper bound; slice i = limit[8*i+7:8*i]; 0 means "any value 0..254".
- ack  out  NUM_REQ  one-hot, one-cycle pulse; rnd_data is valid while it is high.
- rnd_data  out  8  result value; holds its last value until the next ack.
- busy  out  1  high while in DRAW or DONE.

Behaviour:
- Reset is asynchronous active-low: one clock, rst_n asserts asynchronously; release is synchronous to clk. While reset is asserted:
  - LFSR q = SEED (or 8'h01 if SEED = 0).
  - state = IDLE, rr_ptr = 0, ack = 0, rnd_data = 8'h00, busy = 0.
- LFSR:
  - Free-running; advances every cycle in every state.
  - Update: q <= {q[6:0], q[7]^q[5]^q[4]^q[3]}. Period 255; never 0.
  - Sample value s = q - 1, 8-bit, so s ranges over 0..254 and every value appears once per period.
- FSM states: IDLE, DRAW, DONE.
- IDLE:
  - If any req is high, grant the first requester at or after rr_ptr, searching upward with wrap to 0.
  - Latch the granted index to idx and its limit to lim_q. Go to DRAW.
  - Limit is sampled only at grant; later changes to limit are ignored.
- DRAW, each cycle:
  - If req[idx] = 0: abandon without ack and go to IDLE; rr_ptr unchanged.
  - Else if lim_q = 0 or s < lim_q: rnd_data <= s, go to DONE.
  - Else retry next cycle; the LFSR has already advanced.
  - Every bound 1..255 terminates within 255 DRAW cycles.
- DONE:
  - ack[idx] = 1 for exactly this cycle.
  - rr_ptr <= idx+1, wrapping from NUM_REQ-1 to 0. Go to IDLE.
- Latency: req seen in IDLE at edge N; first sample at edge N+1; ack high in the cycle after edge N+1 at the earliest, i.e. 2 cycles.
- A requester must drop req in the cycle after its ack. If req is still high in the next IDLE cycle, it is treated as a new request; it gets no priority because rr_ptr has moved past it.
- Simultaneous requests: only one grant per IDLE cycle; the others wait. No starvation: each waiting requester is served within NUM_REQ grants.
- Reset mid-DRAW or mid-DONE: no ack is issued and all state returns to reset values.

Optional Feature:
- Macro RNG_SCHED_MASK_EN.
- Defined:
  - In DRAW, the compared value is s_m = s & mask. mask is the smallest 2^k-1 that is >= lim_q-1; lim_q = 0 or lim_q = 1 gives mask 8'hFF or 8'h00 respectively.
  - Accept if lim_q = 0 or s_m < lim_q; rnd_data <= s_m.
  - Fewer than 2 expected retries; accepted values are no longer guaranteed to cover each s once per period.
- Undefined: plain compare of s as above. The mask logic is not synthesized.

Test Plan:
- Reset with SEED = 1; raise req[0] with limit0 = 0 at the first edge after release -> ack[0] pulses in cycle 3 with rnd_data = 8'h01 (q = 02); busy high in cycles 2..3.
- req[0], limit0 = 8'd8, issued at the same time as the previous test -> q sequence 02,04,08,11 gives s = 1 (accept) -> rnd_data = 8'h01. Repeat immediately with req held -> s values 0x10, 0x22, 0x46, ... are rejected until s < 8; rnd_data < 8; number of DRAW cycles matches the LFSR model.
- limit0 = 1 (mask macro off) -> ack only when s = 0 (q = 01); DRAW lasts at most 255 cycles; rnd_data = 8'h00.
- req = 4'b1111 held continuously, each requester re-raising after its ack -> ack order 0,1,2,3,0,...; exactly one ack per DONE cycle.
- req[2] granted with limit 1, then dropped mid-DRAW -> return to IDLE, no ack, rnd_data unchanged, rr_ptr still 2 so req[2]/req[3] keep priority.
- rst_n pulsed low mid-DRAW -> ack = 0, rnd_data = 0, busy = 0 immediately (asynchronously); after release the LFSR restarts at SEED.
